// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin time-shared consecutive-ones run detector over serial channels
module seq_det_sched #(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH-1:0]   req_bit,
  output logic [NCH-1:0]   req_ack,
  output logic             det_valid,
  output logic [1:0]       det_ch,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_data,
  input  logic             cnt_clr
);
  localparam int RW = $clog2(RUN_LEN);
  localparam logic [RW-1:0] RMAX = RW'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [1:0] rr_q, rr_d, gnt, idx, det_ch_q, det_ch_d;
  logic gnt_ok, active, hit, det_valid_q, det_valid_d;
  logic [RW-1:0] r_q [NCH];
  logic [RW-1:0] r_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CNT_W-1:0] base;
  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign cnt_data  = cnt_q[cnt_sel];
  // Round-robin pick: scanning downward and overwriting leaves the first valid channel at or after rr_q
  always_comb begin
    gnt    = rr_q;
    gnt_ok = 1'b0;
    idx    = rr_q;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (req_valid[idx]) begin
        gnt_ok = 1'b1;
        gnt    = idx;
      end
    end
    active  = en & ~reset & gnt_ok;
    req_ack = active ? NCH'(1) << gnt : '0;
    hit     = active & req_bit[gnt] & (r_q[gnt] == RMAX);
  end
  // Next state: only the granted channel's run advances; clear is applied before a same-edge count
  always_comb begin
    rr_d        = active ? gnt + 2'd1 : rr_q;
    det_valid_d = hit;
    det_ch_d    = hit ? gnt : det_ch_q;
    base        = '0;
    for (int i = 0; i < NCH; i++) begin
      r_d[i]   = (active && gnt == 2'(i)) ? (req_bit[i] ? ((r_q[i] == RMAX) ? RMAX : r_q[i] + 1'b1) : '0) : r_q[i];
      base     = (cnt_clr && cnt_sel == 2'(i)) ? '0 : cnt_q[i];
      cnt_d[i] = (hit && gnt == 2'(i) && base != CMAX) ? base + 1'b1 : base;
    end
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q        <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      for (int i = 0; i < NCH; i++) begin
        r_q[i]   <= r_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed and randomized checks against a streak-counting reference model
module tb_seq_det_sched;
  localparam int RUN_LEN = 3;
  localparam int CMAX = 3;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, cnt_clr = 1'b0;
  logic [3:0] req_valid = '0, req_bit = '0, req_ack;
  logic det_valid;
  logic [1:0] det_ch, cnt_sel = '0;
  logic [1:0] cnt_data;
  int errors = 0, checks = 0;
  int m_streak [4];
  int m_cnt [4];
  int m_rr, m_dch;
  bit m_dv;
  seq_det_sched #(.NCH(4), .RUN_LEN(RUN_LEN), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_bit(req_bit),
    .req_ack(req_ack), .det_valid(det_valid), .det_ch(det_ch),
    .cnt_sel(cnt_sel), .cnt_data(cnt_data), .cnt_clr(cnt_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_streak[i] = 0;
      m_cnt[i] = 0;
    end
    m_rr = 0;
    m_dv = 0;
    m_dch = 0;
  endtask
  task automatic step(input logic e, input logic [3:0] v, input logic [3:0] b, input logic [1:0] s, input logic c);
    int g;
    bit hit;
    logic [3:0] exp_ack;
    en = e; req_valid = v; req_bit = b; cnt_sel = s; cnt_clr = c;
    #1;
    g = -1;
    if (e) for (int k = 0; k < 4; k++) if (g < 0 && v[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    exp_ack = (g < 0) ? 4'b0 : 4'(1 << g);
    chk("req_ack", 32'(req_ack), 32'(exp_ack));
    chk("det_valid", 32'(det_valid), 32'(m_dv));
    if (m_dv) chk("det_ch", 32'(det_ch), 32'(m_dch));
    chk("cnt_data", 32'(cnt_data), 32'(m_cnt[s]));
    hit = 0;
    if (g >= 0) begin
      m_streak[g] = b[g] ? m_streak[g] + 1 : 0;
      hit = b[g] && m_streak[g] >= RUN_LEN;
      m_rr = (g + 1) % 4;
    end
    if (c) m_cnt[s] = 0;
    if (hit) m_cnt[g] = (m_cnt[g] + 1 > CMAX) ? CMAX : m_cnt[g] + 1;
    m_dv = hit;
    if (hit) m_dch = g;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    en = 1'b1; req_valid = 4'hF; req_bit = 4'hF; cnt_clr = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_det_valid", 32'(det_valid), 0);
    chk("rst_det_ch", 32'(det_ch), 0);
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      chk("rst_cnt", 32'(cnt_data), 0);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    model_clear();
    #2;
    chk("rst_ack0", 32'(req_ack), 0);
    @(negedge clk);
    do_reset();
    step(1, 4'h1, 4'h1, 0, 0);
    step(1, 4'h1, 4'h1, 0, 0);
    step(1, 4'h1, 4'h1, 0, 0);
    chk("lit31_det1", 32'(det_valid), 1);
    chk("lit31_ch", 32'(det_ch), 0);
    step(1, 4'h1, 4'h1, 0, 0);
    chk("lit31_det2", 32'(det_valid), 1);
    step(1, 4'h1, 4'h0, 0, 0);
    chk("lit31_nodet", 32'(det_valid), 0);
    step(1, 4'h1, 4'h1, 0, 0);
    chk("lit31_cnt", 32'(cnt_data), 2);
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      if (c == 1) begin
        en = 1; req_valid = 4'hF; req_bit = 4'hF; #1;
        chk("lit32_ack1", 32'(req_ack), 1);
      end
      if (c >= 10) begin
        chk("lit32_det", 32'(det_valid), 1);
        chk("lit32_ch", 32'(det_ch), 32'(c - 10));
      end else chk("lit32_nodet", 32'(det_valid), 0);
      step(1, 4'hF, 4'hF, 0, 0);
    end
    do_reset();
    step(1, 4'h2, 4'h2, 0, 0);
    step(1, 4'h2, 4'h2, 0, 0);
    for (int k = 0; k < 5; k++) step(1, 4'h4, 4'($urandom_range(0, 1) << 2), 0, 0);
    step(1, 4'h2, 4'h2, 1, 0);
    chk("lit33_det", 32'(det_valid), 1);
    chk("lit33_ch", 32'(det_ch), 1);
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 4'h8, 4'h8, 3, 0);
    chk("lit34_sat", 32'(cnt_data), 3);
    step(1, 4'h8, 4'h8, 3, 1);
    step(1, 4'h0, 4'h0, 3, 0);
    chk("lit34_clr", 32'(cnt_data), 1);
    do_reset();
    step(1, 4'h1, 4'h1, 0, 0);
    step(1, 4'h1, 4'h1, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 4'h1, 4'h1, 0, 0);
    step(1, 4'h1, 4'h1, 0, 0);
    chk("lit35_det", 32'(det_valid), 1);
    do_reset();
    step(1, 4'h1, 4'h1, 0, 0);
    step(1, 4'h1, 4'h1, 0, 0);
    do_reset();
    step(1, 4'h1, 4'h1, 0, 0);
    chk("lit35_nodet", 32'(det_valid), 0);
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i); #1;
      chk("lit35_cnt0", 32'(cnt_data), 0);
    end
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 7) != 0, 4'($urandom), 4'($urandom_range(0, 3) != 0 ? 4'hF ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15)) : 4'($urandom)),
                2'($urandom), $urandom_range(0, 19) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
